// File: rtl/doc_pkg.sv
// doc_pkg: shared constants and types for the document UART receive path.
//   - Document geometry (32 columns x 15 rows, address {row[3:0], col[4:0]}).
//   - Control characters and the printable range.
//   - RX FSM state encoding.
// Optional build macro: UART_RX_PARITY_EN adds the RX_PARITY state.
package doc_pkg;

    localparam int DOC_COLS = 32;
    localparam int DOC_ROWS = 15;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_EOT   = 8'h04;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_LO) && (c <= PRINT_HI);
    endfunction

endpackage

// File: rtl/uart_doc_receiver_rx_core.sv
// uart_rx_core: serial front end of the document receiver.
// Synchronises rx, generates a 16x oversampling tick and deserialises
// 8N1 frames (8E1 when UART_RX_PARITY_EN is defined).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rx_i                  asynchronous serial input, idles high
//   rx_byte_o             last received byte (valid with byte_valid_o)
//   byte_valid_o          1-cycle pulse: good frame received
//   frame_err_pulse_o     1-cycle pulse: stop bit sampled low
//   parity_err_pulse_o    1-cycle pulse: parity mismatch (UART_RX_PARITY_EN only)
//   active_o              FSM is not idle
//
// state        | meaning
// RX_IDLE      | line idle, waiting for a falling edge
// RX_START     | half-bit wait, confirm start bit is still low
// RX_DATA      | sample 8 data bits, LSB first, one per 16 ticks
// RX_PARITY    | sample even-parity bit (parity build only)
// RX_STOP      | sample stop bit; high = byte good, low = framing error
// RX_WAIT_HIGH | framing error seen, wait for the line to return high
module uart_rx_core
    import doc_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_pulse_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_pulse_o,
`endif
    output logic       active_o
);

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] DIV_M1 = TW'(DIV - 1);

    rx_state_e   state_q, state_d;
    logic        rx_s1_q, rx_s2_q;
    logic [TW-1:0] div_q, div_d;
    logic [3:0]  ticks_q, ticks_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        bv_q, bv_d;
    logic        fe_q, fe_d;
    logic        tick;
`ifdef UART_RX_PARITY_EN
    logic        par_bad_q, par_bad_d;
    logic        pe_q, pe_d;
`endif

    assign tick = (div_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            div_q   <= DIV_M1;
            ticks_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            bv_q    <= 1'b0;
            fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            pe_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            div_q   <= div_d;
            ticks_q <= ticks_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            bv_q    <= bv_d;
            fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            pe_q      <= pe_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ticks_d = ticks_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        bv_d    = 1'b0;
        fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        pe_d      = 1'b0;
`endif
        // Held at reload while idle so the tick phase starts at the edge.
        div_d = (tick || state_q == RX_IDLE) ? DIV_M1 : div_q - 1'b1;

        case (state_q)
            RX_IDLE: begin
                if (!rx_s2_q) begin
                    state_d = RX_START;
                    ticks_d = 4'd7;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (ticks_q == 4'd0) begin
                        if (rx_s2_q) begin
                            state_d = RX_IDLE;
                        end else begin
                            state_d = RX_DATA;
                            ticks_d = 4'd15;
                            bit_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
                            par_bad_d = 1'b0;
`endif
                        end
                    end else begin
                        ticks_d = ticks_q - 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (ticks_q == 4'd0) begin
                        shift_d = {rx_s2_q, shift_q[7:1]};
                        ticks_d = 4'd15;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = RX_PARITY;
`else
                            state_d = RX_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        ticks_d = ticks_q - 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (tick) begin
                    if (ticks_q == 4'd0) begin
                        // Even parity: the parity bit equals the XOR of the data.
                        par_bad_d = rx_s2_q ^ (^shift_q);
                        pe_d      = rx_s2_q ^ (^shift_q);
                        state_d   = RX_STOP;
                        ticks_d   = 4'd15;
                    end else begin
                        ticks_d = ticks_q - 4'd1;
                    end
                end
            end
`endif
            RX_STOP: begin
                if (tick) begin
                    if (ticks_q == 4'd0) begin
                        if (rx_s2_q) begin
`ifdef UART_RX_PARITY_EN
                            bv_d = !par_bad_q;
`else
                            bv_d = 1'b1;
`endif
                            state_d = RX_IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = RX_WAIT_HIGH;
                        end
                    end else begin
                        ticks_d = ticks_q - 4'd1;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s2_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte_o         = shift_q;
    assign byte_valid_o      = bv_q;
    assign frame_err_pulse_o = fe_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_pulse_o = pe_q;
`endif
    assign active_o          = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_doc_receiver.sv
// uart_doc_receiver: UART receive path that fills the 32-column document RAM.
// Printable bytes are written at the current {row, col} pointer through a
// request/grant port; LF, CR and EOT steer the pointer / signal completion.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx                       serial input (8N1, idles high)
//   enable                   0 = discard received bytes (framing still tracked)
//   doc_wr_req/addr/data     write request, {row[3:0], col[4:0]}, character
//   doc_wr_gnt               write accepted this cycle
//   busy                     frame in progress or write pending
//   done                     1-cycle pulse after EOT
//   full                     pointer has passed the last cell (sticky)
//   frame_err, overflow      sticky error flags
//   parity_err               sticky parity error (UART_RX_PARITY_EN only)
// Optional build macro: UART_RX_PARITY_EN (8E1 framing, adds parity_err).
module uart_doc_receiver
    import doc_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int DOC_ROWS = doc_pkg::DOC_ROWS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       enable,
    output logic       doc_wr_req,
    output logic [8:0] doc_wr_addr,
    output logic [7:0] doc_wr_data,
    input  logic       doc_wr_gnt,
    output logic       busy,
    output logic       done,
    output logic       full,
    output logic       frame_err,
    output logic       overflow
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int ROW_W = 4;
    localparam int COL_W = 5;
    localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(DOC_ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(DOC_COLS - 1);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       fe_pulse;
    logic       rx_active;

    logic [ROW_W-1:0] row_q, row_d, row_inc;
    logic [COL_W-1:0] col_q, col_d;
    logic             req_q, req_d;
    logic [8:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             full_q, full_d;
    logic             ferr_q, ferr_d;
    logic             ovf_q, ovf_d;
`ifdef UART_RX_PARITY_EN
    logic             pe_pulse;
    logic             perr_q, perr_d;
`endif

    uart_rx_core #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx_core (
        .clk                (clk),
        .rst                (rst),
        .rx_i               (rx),
        .rx_byte_o          (rx_byte),
        .byte_valid_o       (byte_valid),
        .frame_err_pulse_o  (fe_pulse),
`ifdef UART_RX_PARITY_EN
        .parity_err_pulse_o (pe_pulse),
`endif
        .active_o           (rx_active)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            req_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            full_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            req_q  <= req_d;
            addr_q <= addr_d;
            data_q <= data_d;
            done_q <= done_d;
            full_q <= full_d;
            ferr_q <= ferr_d;
            ovf_q  <= ovf_d;
`ifdef UART_RX_PARITY_EN
            perr_q <= perr_d;
`endif
        end
    end

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        req_d  = req_q;
        addr_d = addr_q;
        data_d = data_q;
        done_d = 1'b0;
        ovf_d  = ovf_q;
        ferr_d = ferr_q | fe_pulse;
`ifdef UART_RX_PARITY_EN
        perr_d = perr_q | pe_pulse;
`endif
        // The row saturates at DOC_ROWS so a trailing LF cannot wrap it.
        row_inc = (row_q == ROW_END) ? row_q : row_q + 1'b1;

        if (req_q && doc_wr_gnt) begin
            req_d = 1'b0;
        end

        if (byte_valid && enable) begin
            if (is_printable(rx_byte)) begin
                if (full_q) begin
                    // Past the last cell: byte dropped silently.
                end else if (req_q && !doc_wr_gnt) begin
                    ovf_d = 1'b1;
                end else begin
                    req_d  = 1'b1;
                    addr_d = {row_q, col_q};
                    data_d = rx_byte;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_inc;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end else if (rx_byte == CH_LF) begin
                col_d = '0;
                row_d = row_inc;
            end else if (rx_byte == CH_CR) begin
                col_d = '0;
            end else if (rx_byte == CH_EOT) begin
                done_d = 1'b1;
            end
        end

        full_d = full_q | (row_d == ROW_END);
    end

    assign doc_wr_req  = req_q;
    assign doc_wr_addr = addr_q;
    assign doc_wr_data = data_q;
    assign busy        = rx_active | req_q;
    assign done        = done_q;
    assign full        = full_q;
    assign frame_err   = ferr_q;
    assign overflow    = ovf_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_uart_doc_receiver.sv
module tb_uart_doc_receiver;

    // 16x oversampling with a 2-clock tick: one bit lasts 32 clocks.
    localparam int CLK_HZ = 3_200_000;
    localparam int BAUD   = 100_000;
    localparam int BIT    = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       enable;
    logic       doc_wr_req;
    logic [8:0] doc_wr_addr;
    logic [7:0] doc_wr_data;
    logic       doc_wr_gnt = 1'b1;
    logic       busy, done, full, frame_err, overflow;

    uart_doc_receiver #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .DOC_ROWS (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .enable      (enable),
        .doc_wr_req  (doc_wr_req),
        .doc_wr_addr (doc_wr_addr),
        .doc_wr_data (doc_wr_data),
        .doc_wr_gnt  (doc_wr_gnt),
        .busy        (busy),
        .done        (done),
        .full        (full),
        .frame_err   (frame_err),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Model state: linear cell index 0..480, 480 means "past the last cell".
    int           m_pos;
    bit           m_ferr, m_ovf;
    int           exp_done;
    int           done_seen;
    logic [16:0]  exp_q[$];
    logic [16:0]  log_q[$];
    int           gnt_mode;   // 0: gnt=1, 1: gnt=0, 2: random
    logic         done_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic bit m_full();
        return m_pos >= 480;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit en);
        if (!en) return;
        if (b >= 8'h20 && b <= 8'h7E) begin
            if (m_full()) begin
            end else if (gnt_mode == 1 && exp_q.size() > 0) begin
                m_ovf = 1'b1;
            end else begin
                exp_q.push_back({9'((m_pos / 32) * 32 + (m_pos % 32)), b});
                m_pos++;
            end
        end else if (b == 8'h0A) begin
            m_pos = (m_pos / 32 + 1) * 32;
            if (m_pos > 480) m_pos = 480;
        end else if (b == 8'h0D) begin
            m_pos = (m_pos / 32) * 32;
        end else if (b == 8'h04) begin
            exp_done++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        m_pos = 0; m_ferr = 0; m_ovf = 0; exp_done = 0; done_seen = 0;
        exp_q.delete();
        log_q.delete();
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) model_byte(b, enable);
        else m_ferr = 1'b1;
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_ok;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic settle();
        if (gnt_mode != 1) begin
            for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        end
    endtask

    task automatic check_state(input string tag);
        settle();
        chk({tag, "_full"}, full, m_full());
        chk({tag, "_frame_err"}, frame_err, m_ferr);
        chk({tag, "_overflow"}, overflow, m_ovf);
        chk({tag, "_busy"}, busy, (gnt_mode == 1 && exp_q.size() > 0));
        chk({tag, "_done_count"}, done_seen, exp_done);
        if (gnt_mode != 1) chk({tag, "_writes_left"}, exp_q.size(), 0);
    endtask

    // gnt changes shortly after the rising edge and is stable for the compare.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (gnt_mode)
                0:       doc_wr_gnt = 1'b1;
                1:       doc_wr_gnt = 1'b0;
                default: doc_wr_gnt = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: every cycle a write is presented it must match the
    // oldest expected write; done must never last more than one cycle.
    initial begin
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0;
            end else begin
                if (doc_wr_req) begin
                    if (exp_q.size() == 0) begin
                        chk("wr_req_unexpected", doc_wr_req, 1'b0);
                    end else begin
                        chk("wr_addr", doc_wr_addr, exp_q[0][16:8]);
                        chk("wr_data", doc_wr_data, exp_q[0][7:0]);
                        if (doc_wr_gnt) begin
                            log_q.push_back({doc_wr_addr, doc_wr_data});
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (done) begin
                    chk("done_width", done_prev, 1'b0);
                    done_seen++;
                end
                done_prev = done;
            end
        end
    end

    initial begin
        logic [16:0] e;
        logic [7:0]  b;
        int          n;
        int          kind;
        rst = 1'b1; rx = 1'b1; enable = 1'b1; gnt_mode = 0;
        m_pos = 0; m_ferr = 0; m_ovf = 0; exp_done = 0; done_seen = 0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", doc_wr_req, 0);
        chk("rst_addr", doc_wr_addr, 0);
        chk("rst_data", doc_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_full", full, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overflow", overflow, 0);

        // Single 'A'
        send_frame(8'h41, 1);
        check_state("a");
        chk("a_log_size", log_q.size(), 1);
        if (log_q.size() > 0) begin
            e = log_q[0];
            chk("a_write", e, {9'h000, 8'h41});
        end
        chk("a_model_pos", m_pos, 1);

        // "AB", LF, "C"
        do_reset();
        send_frame(8'h41, 1);
        send_frame(8'h42, 1);
        send_frame(8'h0A, 1);
        send_frame(8'h43, 1);
        check_state("ablfc");
        chk("ablfc_log_size", log_q.size(), 3);
        if (log_q.size() == 3) begin
            e = log_q[0]; chk("ablfc_w0", e, {9'h000, 8'h41});
            e = log_q[1]; chk("ablfc_w1", e, {9'h001, 8'h42});
            e = log_q[2]; chk("ablfc_w2", e, {9'h020, 8'h43});
        end

        // 3-clock glitch on the idle line
        log_q.delete();
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        n = 0;
        while (busy && n < 24) begin
            @(negedge clk);
            n++;
        end
        chk("glitch_busy_clear", busy, 0);
        chk("glitch_frame_err", frame_err, 0);
        chk("glitch_no_write", log_q.size(), 0);

        // Stop bit low, then a good 0x5A
        send_frame(8'hA5, 0);
        check_state("badstop");
        chk("badstop_frame_err", frame_err, 1);
        chk("badstop_no_write", log_q.size(), 0);
        send_frame(8'h5A, 1);
        check_state("after_badstop");
        chk("after_badstop_log", log_q.size(), 1);
        if (log_q.size() > 0) begin
            e = log_q[0];
            chk("after_badstop_data", e[7:0], 8'h5A);
        end

        // Overflow with gnt held low
        log_q.delete();
        gnt_mode = 1;
        send_frame(8'h58, 1);
        send_frame(8'h59, 1);
        repeat (4) @(negedge clk);
        check_state("ovf_hold");
        chk("ovf_req_held", doc_wr_req, 1);
        chk("ovf_data_held", doc_wr_data, 8'h58);
        chk("ovf_flag", overflow, 1);
        gnt_mode = 0;
        repeat (4) @(negedge clk);
        check_state("ovf_release");
        chk("ovf_log_size", log_q.size(), 1);
        if (log_q.size() > 0) begin
            e = log_q[0];
            chk("ovf_written", e[7:0], 8'h58);
        end

        // Randomised traffic with random grant and enable
        do_reset();
        gnt_mode = 2;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 15);
            enable = ($urandom_range(0, 7) != 0);
            case (kind)
                0:       b = 8'h0A;
                1:       b = 8'h0D;
                2:       b = 8'h04;
                3:       b = ($urandom_range(0, 1) != 0) ? 8'h7F : 8'($urandom_range(128, 255));
                default: b = 8'($urandom_range(32, 126));
            endcase
            send_frame(b, kind != 4);
            check_state("rand");
        end
        enable = 1'b1;

        // Fill to the last cell, then one extra byte and EOT
        do_reset();
        gnt_mode = 0;
        for (int i = 0; i < 14; i++) send_frame(8'h0A, 1);
        for (int i = 0; i < 32; i++) send_frame(8'($urandom_range(32, 126)), 1);
        send_frame(8'h5A, 1);
        send_frame(8'h04, 1);
        check_state("full");
        chk("full_log_size", log_q.size(), 32);
        if (log_q.size() > 0) begin
            e = log_q[log_q.size() - 1];
            chk("full_last_addr", e[16:8], 9'h1DF);
            e = log_q[0];
            chk("full_first_addr", e[16:8], 9'h1C0);
        end
        chk("full_flag", full, 1);
        chk("full_done_once", done_seen, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
